// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, clog2 helper and default sizes for mem_port_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam int DEF_LATENCY = 3;
   localparam int DEF_DSIZE   = 16;
   localparam int DEF_ASIZE   = 16;
   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational request picker, round-robin from a pointer or fixed priority.
//   Macro MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, pointer ignored).
//   i_req [N]  request vector      i_ptr [IW]  round-robin start index
//   o_gnt [N]  one-hot grant       o_idx [IW]  encoded grant index (0 when no request)
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);
`ifdef MEM_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) if (i_req[i]) o_idx = IW'(i);
      o_gnt = (|i_req) ? (N'(1) << o_idx) : '0;
   end
`else
   // Scan offsets downward so the smallest offset from the pointer is the last writer.
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (i_req[(int'(i_ptr) + i) % N]) o_idx = IW'((int'(i_ptr) + i) % N);
      o_gnt = (|i_req) ? (N'(1) << o_idx) : '0;
   end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NUM_PORTS requesters sharing one word memory with fixed access latency.
//   Macro MEM_ARB_FIXED_PRIO_EN: fixed priority (port 0 highest) instead of round-robin.
//   clk, rst (async, active-low)
//   req_valid/req_wen(0=write)/req_addr/req_wdata : per-port requests, flattened by port
//   resp_valid : one-cycle completion pulse per port, resp_rdata : read data
//   busy : grant through completion, grant_id : port currently / last served
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   parameter  int ASIZE     = DEF_ASIZE,
   parameter  int DSIZE     = DEF_DSIZE,
   parameter  int DEPTH     = 1024,
   parameter  int LATENCY   = DEF_LATENCY,
   localparam int IW        = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       req_valid,
   input  logic [NUM_PORTS-1:0]       req_wen,
   input  logic [NUM_PORTS*ASIZE-1:0] req_addr,
   input  logic [NUM_PORTS*DSIZE-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]       resp_valid,
   output logic [DSIZE-1:0]           resp_rdata,
   output logic                       busy,
   output logic [IW-1:0]              grant_id
);
   localparam int AW = clog2(DEPTH);
   state_t               r_state, w_next;
   logic [IW-1:0]        r_port, w_ptr, w_idx;
   logic [NUM_PORTS-1:0] w_gnt, r_resp_valid;
   logic [AW-1:0]        r_addr;
   logic [DSIZE-1:0]     r_wdata, r_rdata;
   logic [DSIZE-1:0]     r_mem [DEPTH];
   logic                 r_wen, r_busy;
   logic [3:0]           r_cnt;
   logic [ASIZE-1:0]     w_req_addr;
   logic                 w_unused;
   rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
      .i_req (req_valid),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );
   assign w_req_addr = req_addr[int'(w_idx) * ASIZE +: ASIZE];
   // Upper address bits are dropped on purpose: addresses wrap modulo DEPTH.
   assign w_unused   = ^{w_req_addr, w_gnt};
`ifdef MEM_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [IW-1:0] r_ptr;
   assign w_ptr = r_ptr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_ptr <= '0;
      else if (r_state == RESP)
         r_ptr <= (int'(r_port) == NUM_PORTS - 1) ? '0 : r_port + 1'b1;
   end
`endif
   always_comb begin
      w_next = (r_state == IDLE)   ? ((|req_valid) ? ACCESS : IDLE) :
               (r_state == ACCESS) ? ((r_cnt == '0) ? RESP : ACCESS) : IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_port       <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wen        <= 1'b1;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_resp_valid <= '0;
         r_rdata      <= '0;
      end else begin
         r_state      <= w_next;
         r_resp_valid <= '0;
         if (r_state == IDLE && |req_valid) begin
            r_port  <= w_idx;
            r_addr  <= w_req_addr[AW-1:0];
            r_wdata <= req_wdata[int'(w_idx) * DSIZE +: DSIZE];
            r_wen   <= req_wen[w_idx];
            r_busy  <= 1'b1;
            r_cnt   <= 4'(LATENCY - 1);
         end
         if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
               if (r_wen) r_rdata <= r_mem[r_addr];
               r_resp_valid[r_port] <= 1'b1;
            end
         end
         if (r_state == RESP) r_busy <= 1'b0;
      end
   end
   // Memory is never reset; an async reset forces IDLE so an aborted access cannot commit.
   always_ff @(posedge clk) begin
      if (r_state == ACCESS && r_cnt == '0 && !r_wen) r_mem[r_addr] <= r_wdata;
   end
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign busy       = r_busy;
   assign grant_id   = r_port;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized multi-port traffic against a transaction model.
module tb_mem_port_arbiter;
   localparam int L = 3;
   logic        clk, rst;
   logic [3:0]  req_valid, req_wen, resp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [15:0] resp_rdata;
   logic        busy;
   logic [1:0]  grant_id;
   int          total, bad;
   logic [15:0] m_mem [1024];
   int          m_ptr, m_gid;
   logic [15:0] m_last, rd, pre, t_exp;
   logic [3:0]  act, t_wen;
   logic [15:0] t_addr [4];
   logic [15:0] t_dat [4];
   int          order [5];
   int          e, m_free, t_port, t_end;
   bit          m_busy, t_read, done;
   mem_port_arbiter #(.NUM_PORTS(4), .ASIZE(16), .DSIZE(16), .DEPTH(1024), .LATENCY(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .busy       (busy),
      .grant_id   (grant_id)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic int arb(input logic [3:0] r, input int ptr);
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
      for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
      return 0;
   endfunction
   task automatic op(input int p, input logic wen, input logic [15:0] addr,
                     input logic [15:0] wdata, output logic [15:0] rdo);
      if (!wen) m_mem[addr[9:0]] = wdata;
      else m_last = m_mem[addr[9:0]];
      req_valid = 4'(1 << p);
      req_wen[p] = wen;
      req_addr[p*16 +: 16] = addr;
      req_wdata[p*16 +: 16] = wdata;
      m_ptr = (p + 1) % 4;
      @(posedge clk); #1;
      chk("op_busy", busy, 1);
      chk("op_gid", grant_id, p);
      chk("op_rv_early", resp_valid, 0);
      for (int k = 1; k <= L; k++) begin
         @(posedge clk); #1;
         chk("op_rv", resp_valid, (k == L) ? (32'd1 << p) : 32'd0);
         chk("op_busy_hold", busy, 1);
      end
      chk("op_rdata", resp_rdata, m_last);
      rdo = resp_rdata;
      req_valid = '0;
      @(posedge clk); #1;
      chk("op_rv_end", resp_valid, 0);
      chk("op_idle", busy, 0);
   endtask
   task automatic new_txn(input int p);
      logic [15:0] a;
      a = 16'($urandom_range(0, 31));
      a[15:10] = 6'($urandom);
      act[p] = 1'b1;
      t_wen[p] = 1'($urandom_range(0, 1));
      t_addr[p] = a;
      t_dat[p] = 16'($urandom);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      clk = 0; rst = 0; req_valid = '0; req_wen = '1; req_addr = '0; req_wdata = '0;
      total = 0; bad = 0; m_ptr = 0; m_last = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rv", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_rdata", resp_rdata, 0);
      rst = 1;
      for (int a = 0; a < 32; a++)
         op(a % 4, 1'b0, 16'(a), (a < 4) ? 16'(32'hA0 + a) : 16'($urandom), rd);
      op(0, 1'b0, 16'h0004, 16'h1234, rd);
      op(0, 1'b1, 16'h0004, 16'h0000, rd);
      chk("rw_read", rd, 16'h1234);
      op(2, 1'b0, 16'h0405, 16'h5A5A, rd);
      op(3, 1'b1, 16'h0005, 16'h0000, rd);
      chk("wrap_read", rd, 16'h5A5A);
      pre = m_mem[16];
      req_valid = 4'b0010; req_wen[1] = 1'b0; req_addr[31:16] = 16'h0010; req_wdata[31:16] = 16'hBEEF;
      @(posedge clk); #1;
      chk("rm_busy", busy, 1);
      repeat (2) begin @(posedge clk); #1; end
      rst = 0; req_valid = '0;
      #1;
      chk("rm_rv", resp_valid, 0);
      chk("rm_busy_clr", busy, 0);
      chk("rm_gid", grant_id, 0);
      repeat (3) begin @(posedge clk); #1; chk("rm_rv_hold", resp_valid, 0); end
      rst = 1; m_ptr = 0; m_last = '0;
      op(0, 1'b1, 16'h0010, 16'h0000, rd);
      chk("rm_no_commit", rd, pre);
      for (int g = 0; g < 5; g++) begin
         order[g] = arb(4'hF, m_ptr);
         m_ptr = (order[g] + 1) % 4;
      end
      req_valid = 4'hF; req_wen = 4'hF;
      for (int p = 0; p < 4; p++) req_addr[p*16 +: 16] = 16'(p);
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         if (c >= 4 && (c - 4) % 5 == 0) begin
            chk("rr_rv", resp_valid, 32'd1 << order[(c - 4) / 5]);
            chk("rr_gid", grant_id, order[(c - 4) / 5]);
            chk("rr_rdata", resp_rdata, 32'hA0 + order[(c - 4) / 5]);
         end else chk("rr_rv_idle", resp_valid, 0);
      end
      req_valid = '0;
      m_last = 16'(32'hA0 + order[4]);
      m_gid = order[4];
      @(posedge clk); #1;
      act = '0; m_busy = 0; m_free = 0; e = 0; t_port = 0; t_end = 0; t_read = 0; t_exp = '0;
      for (int it = 0; it < 1500; it++) begin
         for (int p = 0; p < 4; p++) if (!act[p] && $urandom_range(0, 2) == 0) new_txn(p);
         req_valid = act;
         req_wen = t_wen;
         for (int p = 0; p < 4; p++) begin
            req_addr[p*16 +: 16] = t_addr[p];
            req_wdata[p*16 +: 16] = t_dat[p];
         end
         @(posedge clk);
         e++;
         if (!m_busy && e >= m_free && act != '0) begin
            t_port = arb(act, m_ptr);
            m_ptr = (t_port + 1) % 4;
            m_gid = t_port;
            t_end = e + L;
            m_free = e + L + 2;
            m_busy = 1;
            t_read = t_wen[t_port];
            t_exp = m_mem[t_addr[t_port][9:0]];
            if (!t_read) m_mem[t_addr[t_port][9:0]] = t_dat[t_port];
            t_addr[t_port] = 16'($urandom);
            t_dat[t_port] = 16'($urandom);
            t_wen[t_port] = 1'($urandom_range(0, 1));
         end
         #1;
         done = m_busy && e == t_end;
         if (done && t_read) m_last = t_exp;
         chk("rnd_rv", resp_valid, done ? (32'd1 << t_port) : 32'd0);
         chk("rnd_busy", busy, m_busy);
         chk("rnd_gid", grant_id, m_gid);
         chk("rnd_rdata", resp_rdata, m_last);
         if (done) begin
            m_busy = 0;
            act[t_port] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_txn(t_port);
         end
      end
      req_valid = '0;
      repeat (L + 3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
